// File: rtl/apu_control_n_if.sv
// CPU-side register bus into the APU master-control block.
interface apu_control_n_if;
   logic [3:0] reg_sel;
   logic       reg_wr;
   logic       reg_rd;
   logic [7:0] wdata;
   logic [7:0] rdata;

   modport master (
      output reg_sel, reg_wr, reg_rd, wdata,
      input  rdata
   );

   modport slave (
      input  reg_sel, reg_wr, reg_rd, wdata,
      output rdata
   );
endinterface

// File: rtl/apu_control_n.sv
// APU master control: volume/pan/power registers, clock enables, frame sequencer.
// Optional VIN enables stored only when APU_CTRL_VIN_EN is defined.
module apu_control_n #(
   parameter int NUM_CH   = 4,
   parameter int PAN_REGS = (2*NUM_CH+7)/8,
   parameter int FAST_DIV = 16
) (
   input  logic              apuv_4mhz,
   input  logic              nreset,
   apu_control_n_if.slave    bus,
   input  logic              tick_512hz,
   input  logic [NUM_CH-1:0] ch_active,
   output logic              apu_reset,
   output logic              en_2mhz,
   output logic              en_1mhz,
   output logic              len_tick,
   output logic              sweep_tick,
   output logic              env_tick,
   output logic [2:0]        lvol,
   output logic [2:0]        rvol,
   output logic              vin_l_ena,
   output logic              vin_r_ena,
   output logic [NUM_CH-1:0] lmix,
   output logic [NUM_CH-1:0] rmix
);
   localparam int PW = 8*PAN_REGS;
   localparam int FW = $clog2(FAST_DIV);
   localparam logic [PW-1:0] USED = PW'((64'd1 << (2*NUM_CH)) - 64'd1);

   logic [1:0]    c;
   logic          power;
   logic          fast;
   logic [PW-1:0] pan;
   logic          tick_q;
   logic [FW-1:0] fcnt;
   logic [2:0]    step;
   logic          wr_vol, wr_ctl, pwr_off, pwr_on;
   logic          fast_run, fast_tc, slow_rise, tick;
   logic [7:0]    rd_val, ctl_val, vol_val;
   logic [PW-1:0] pan_rd;

   assign en_2mhz   = c[0];
   assign en_1mhz   = &c;
   assign apu_reset = ~power;

   assign wr_vol    = bus.reg_wr && bus.reg_sel == 4'd0 && power;
   assign wr_ctl    = bus.reg_wr && bus.reg_sel == 4'd1;
   assign pwr_off   = wr_ctl && power && !bus.wdata[7];
   assign pwr_on    = wr_ctl && !power && bus.wdata[7];
   assign fast_run  = power && fast;
   assign fast_tc   = fast_run && fcnt == FW'(FAST_DIV-1);
   assign slow_rise = tick_512hz && !tick_q;
   // a power-off write on the same edge swallows the tick
   assign tick      = power && !pwr_off && (fast ? fast_tc : slow_rise);

   assign vol_val = {vin_l_ena, lvol, vin_r_ena, rvol};
   assign pan_rd  = pan | ~USED;

   always_comb begin
      rmix = '0;
      lmix = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         rmix[k] = pan[2*k];
         lmix[k] = pan[2*k+1];
      end
   end

   always_comb begin
      ctl_val = {power, 7'h7F};
      ctl_val[NUM_CH-1:0] = ch_active;
      rd_val = 8'hFF;
      if (bus.reg_sel == 4'd0) rd_val = vol_val;
      if (bus.reg_sel == 4'd1) rd_val = ctl_val;
      for (int r = 0; r < PAN_REGS; r++)
         if (bus.reg_sel == 4'(2+r)) rd_val = pan_rd[8*r +: 8];
   end

   always_ff @(posedge apuv_4mhz or negedge nreset) begin
      if (!nreset) begin
         c          <= '0;
         power      <= 1'b0;
         fast       <= 1'b0;
         lvol       <= '0;
         rvol       <= '0;
         pan        <= '0;
         tick_q     <= 1'b0;
         fcnt       <= '0;
         step       <= '0;
         len_tick   <= 1'b0;
         sweep_tick <= 1'b0;
         env_tick   <= 1'b0;
         bus.rdata  <= '0;
      end else begin
         c          <= c + 2'd1;
         tick_q     <= tick_512hz;
         fcnt       <= fast_run ? fcnt + FW'(1) : '0;
         len_tick   <= tick && !step[0];
         sweep_tick <= tick && step[1:0] == 2'd2;
         env_tick   <= tick && step == 3'd7;
         bus.rdata  <= bus.reg_rd ? rd_val : 8'h00;
         if (tick) step <= step + 3'd1;
         if (wr_ctl) begin
            power <= bus.wdata[7];
            fast  <= pwr_off ? 1'b0 : bus.wdata[6];
         end
         if (pwr_off || pwr_on) step <= '0;
         if (pwr_off) begin
            lvol <= '0;
            rvol <= '0;
            pan  <= '0;
         end
         if (wr_vol) begin
            lvol <= bus.wdata[6:4];
            rvol <= bus.wdata[2:0];
         end
         for (int r = 0; r < PAN_REGS; r++)
            if (power && bus.reg_wr && bus.reg_sel == 4'(2+r))
               pan[8*r +: 8] <= bus.wdata;
      end
   end

`ifdef APU_CTRL_VIN_EN
   always_ff @(posedge apuv_4mhz or negedge nreset) begin
      if (!nreset) begin
         vin_l_ena <= 1'b0;
         vin_r_ena <= 1'b0;
      end else if (pwr_off) begin
         vin_l_ena <= 1'b0;
         vin_r_ena <= 1'b0;
      end else if (wr_vol) begin
         vin_l_ena <= bus.wdata[7];
         vin_r_ena <= bus.wdata[3];
      end
   end
`else
   assign vin_l_ena = 1'b0;
   assign vin_r_ena = 1'b0;
`endif
endmodule

// File: tb/tb_apu_control_n.sv
// Directed + randomized bench for apu_control_n against a rule-level model.
module tb_apu_control_n;
   localparam int NC = 4;
   localparam int FD = 16;
   localparam int PR = (2*NC+7)/8;

   logic          clk = 1'b0;
   logic          nreset;
   logic          tick_512hz;
   logic [NC-1:0] ch_active;
   logic          apu_reset, en_2mhz, en_1mhz;
   logic          len_tick, sweep_tick, env_tick;
   logic [2:0]    lvol, rvol;
   logic          vin_l_ena, vin_r_ena;
   logic [NC-1:0] lmix, rmix;

   apu_control_n_if bus ();

   apu_control_n #(.NUM_CH(NC), .FAST_DIV(FD)) dut (
      .apuv_4mhz (clk),
      .nreset    (nreset),
      .bus       (bus),
      .tick_512hz(tick_512hz),
      .ch_active (ch_active),
      .apu_reset (apu_reset),
      .en_2mhz   (en_2mhz),
      .en_1mhz   (en_1mhz),
      .len_tick  (len_tick),
      .sweep_tick(sweep_tick),
      .env_tick  (env_tick),
      .lvol      (lvol),
      .rvol      (rvol),
      .vin_l_ena (vin_l_ena),
      .vin_r_ena (vin_r_ena),
      .lmix      (lmix),
      .rmix      (rmix)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   logic          m_power, m_fast, m_vinl, m_vinr;
   logic [2:0]    m_lvol, m_rvol;
   logic [8*PR-1:0] m_pan;
   int            m_step;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic m_reset();
      m_power = 0; m_fast = 0; m_vinl = 0; m_vinr = 0;
      m_lvol = 0; m_rvol = 0; m_pan = '0; m_step = 0;
   endtask

   function automatic logic [2:0] pulses(input int s);
      return {s % 2 == 0, s == 2 || s == 6, s == 7};
   endfunction

   function automatic logic [7:0] exp_rd(input int sel);
      logic [7:0] v;
      int idx;
      v = 8'hFF;
      if (sel == 0) v = {m_vinl, m_lvol, m_vinr, m_rvol};
      else if (sel == 1) begin
         v = {m_power, 7'h7F};
         for (int i = 0; i < NC; i++) v[i] = ch_active[i];
      end else if (sel < 2 + PR) begin
         for (int b = 0; b < 8; b++) begin
            idx = 8*(sel-2) + b;
            v[b] = (idx < 2*NC) ? m_pan[idx] : 1'b1;
         end
      end
      return v;
   endfunction

   task automatic m_write(input int sel, input logic [7:0] d);
      if (sel == 1) begin
         if (m_power && !d[7]) begin
            m_lvol = 0; m_rvol = 0; m_vinl = 0; m_vinr = 0;
            m_pan = '0; m_fast = 0; m_step = 0;
         end else begin
            m_fast = d[6];
            if (!m_power && d[7]) m_step = 0;
         end
         m_power = d[7];
      end else if (m_power && sel == 0) begin
         m_lvol = d[6:4];
         m_rvol = d[2:0];
`ifdef APU_CTRL_VIN_EN
         m_vinl = d[7];
         m_vinr = d[3];
`endif
      end else if (m_power && sel >= 2 && sel < 2 + PR) begin
         m_pan[8*(sel-2) +: 8] = d;
      end
   endtask

   task automatic wr(input int sel, input logic [7:0] d);
      bus.reg_sel = 4'(sel);
      bus.wdata   = d;
      bus.reg_wr  = 1'b1;
      cyc();
      bus.reg_wr  = 1'b0;
      m_write(sel, d);
   endtask

   task automatic rd(input int sel, input string tag);
      logic [7:0] e;
      bus.reg_sel = 4'(sel);
      bus.reg_rd  = 1'b1;
      e = exp_rd(sel);
      cyc();
      bus.reg_rd  = 1'b0;
      chk(tag, bus.rdata, e);
   endtask

   task automatic chk_outs(input string t);
      logic [NC-1:0] el, er;
      for (int k = 0; k < NC; k++) begin
         er[k] = m_pan[2*k];
         el[k] = m_pan[2*k+1];
      end
      chk({t, ".vol"}, {lvol, rvol}, {m_lvol, m_rvol});
      chk({t, ".mix"}, {lmix, rmix}, {el, er});
      chk({t, ".vin"}, {vin_l_ena, vin_r_ena}, {m_vinl, m_vinr});
      chk({t, ".apu_reset"}, apu_reset, !m_power);
   endtask

   // one slow tick edge held for 'hold' cycles, then two low cycles
   task automatic slow_tick(input string t, input int hold);
      int nl, ns, ne;
      logic [2:0] e;
      nl = 0; ns = 0; ne = 0;
      e = (m_power && !m_fast) ? pulses(m_step) : 3'b000;
      tick_512hz = 1'b1;
      for (int i = 0; i < hold + 2; i++) begin
         if (i == hold) tick_512hz = 1'b0;
         cyc();
         nl += int'(len_tick);
         ns += int'(sweep_tick);
         ne += int'(env_tick);
      end
      chk({t, ".pulses"}, {nl[7:0], ns[7:0], ne[7:0]},
          {7'd0, e[2], 7'd0, e[1], 7'd0, e[0]});
      if (m_power && !m_fast) m_step = (m_step + 1) % 8;
   endtask

   initial begin
      int cexp, n, sel, op;
      logic [2:0] e;
      nreset = 1'b0;
      tick_512hz = 1'b0;
      ch_active = '0;
      bus.reg_sel = '0; bus.reg_wr = 1'b0; bus.reg_rd = 1'b0; bus.wdata = '0;
      m_reset();
      cyc(); cyc();
      chk("rst.apu_reset", apu_reset, 1'b1);
      chk("rst.rdata", bus.rdata, 8'h00);
      chk("rst.pulses", {len_tick, sweep_tick, env_tick}, 3'b000);
      chk("rst.en", {en_2mhz, en_1mhz}, 2'b00);
      chk_outs("rst");

      nreset = 1'b1;
      cexp = 0;
      for (int i = 0; i < 8; i++) begin
         cyc();
         cexp = (cexp + 1) % 4;
         chk("en", {en_2mhz, en_1mhz}, {cexp[0], cexp == 3});
      end

      wr(1, 8'h80);
      wr(0, 8'h77);
      wr(2, 8'hF3);
      chk_outs("pwr_on");
      rd(0, "rd.vol");
      cyc();
      chk("rd.idle", bus.rdata, 8'h00);
      rd(2, "rd.pan");
      rd(3, "rd.undef");
      ch_active = 4'b0101;
      rd(1, "rd.ctl");

      // read and write of the same register: old value returned
      bus.reg_sel = 4'd0; bus.wdata = 8'h23;
      bus.reg_rd = 1'b1; bus.reg_wr = 1'b1;
      e = 3'b0;
      cyc();
      bus.reg_rd = 1'b0; bus.reg_wr = 1'b0;
      chk("rd.rw_old", bus.rdata, {m_vinl, m_lvol, m_vinr, m_rvol});
      m_write(0, 8'h23);
      chk_outs("rw");

      for (int i = 0; i < 60; i++) begin
         op = $urandom_range(0, 2);
         ch_active = NC'($urandom);
         if (op == 0) wr(0, 8'($urandom));
         else if (op == 1) wr($urandom_range(2, 2 + PR), 8'($urandom));
         else begin
            sel = $urandom_range(0, 15);
            rd(sel, "rnd.rd");
         end
         chk_outs("rnd");
      end

      for (int i = 0; i < 9; i++) slow_tick("slow", $urandom_range(1, 4));

      // power-off on the same edge as a tick rise
      tick_512hz = 1'b1;
      wr(1, 8'h00);
      n = 0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n += int'(len_tick | sweep_tick | env_tick);
      end
      tick_512hz = 1'b0;
      chk("off.suppress", n, 0);
      chk_outs("off");
      wr(0, 8'h55);
      rd(0, "off.rd_vol");
      slow_tick("off.tick", 2);

      wr(1, 8'hC0);
      for (int k = 1; k <= 300; k++) begin
         tick_512hz = 1'($urandom);
         cyc();
         e = (k % FD == 0) ? pulses((k / FD - 1) % 8) : 3'b000;
         chk("fast", {len_tick, sweep_tick, env_tick}, e);
      end
      tick_512hz = 1'b0;
      wr(1, 8'h00);
      cyc();

      wr(1, 8'h80);
      wr(0, 8'h35);
      wr(2, 8'h0F);
      for (int i = 0; i < 5; i++) slow_tick("pre_rst", 1);
      chk("pre_rst.step", m_step, 5);
      bus.reg_sel = 4'd0;
      bus.reg_rd = 1'b1;
      cyc();
      #2 nreset = 1'b0;
      #1;
      bus.reg_rd = 1'b0;
      m_reset();
      chk("async.rdata", bus.rdata, 8'h00);
      chk("async.pulses", {len_tick, sweep_tick, env_tick}, 3'b000);
      chk_outs("async");
      cyc();
      nreset = 1'b1;
      cyc();
      wr(1, 8'h80);
      slow_tick("post_rst", 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
